vga_timing_gen: RTL and testbench

- Generates 640x480@60 Hz VGA raster timing in the 25.2 MHz pixel-clock domain produced by the display PLL.
- Consumes the PLL `locked` flag and stays idle/blanked until lock has been qualified. It drops back to idle whenever lock is lost.
- Feeds sync/DE and pixel coordinates to the framebuffer scan-out and DAC/HDMI output stages.

---
 rtl/vga_timing_gen_if.sv | 19 +
 rtl/vga_timing_gen.sv | 153 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle from the raster generator to scan-out and output stages.
interface vga_timing_gen_if;
   logic       hsync_n;
   logic       vsync_n;
   logic       de;
   logic [9:0] x;
   logic [9:0] y;
   logic       line_start;
   logic       frame_start;
   logic       running;

   modport master (
      output hsync_n, vsync_n, de, x, y, line_start, frame_start, running
   );

   modport slave (
      input hsync_n, vsync_n, de, x, y, line_start, frame_start, running
   );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator gated by a qualified PLL lock.
// Outputs are registered decodes of the counters, one cycle behind them.
module vga_timing_gen #(
   parameter int H_ACT       = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACT       = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int LOCK_SETTLE = 1024
) (
   input  logic              refclk,
   input  logic              rst,
   input  logic              locked,
   vga_timing_gen_if.master  vid
);
   localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
   localparam int SW    = (LOCK_SETTLE > 1) ? $clog2(LOCK_SETTLE) : 1;

   localparam logic [9:0]    H_ACT_W     = 10'(H_ACT);
   localparam logic [9:0]    H_SYNC_BEG  = 10'(H_ACT + H_FP);
   localparam logic [9:0]    H_SYNC_END  = 10'(H_ACT + H_FP + H_SYNC);
   localparam logic [9:0]    H_LAST      = 10'(H_TOT - 1);
   localparam logic [9:0]    V_ACT_W     = 10'(V_ACT);
   localparam logic [9:0]    V_SYNC_BEG  = 10'(V_ACT + V_FP);
   localparam logic [9:0]    V_SYNC_END  = 10'(V_ACT + V_FP + V_SYNC);
   localparam logic [9:0]    V_LAST      = 10'(V_TOT - 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_SETTLE - 1);

   typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;

   state_t        state_reg, state_next;
   logic          lock_meta_reg, locked_s_reg;
   logic [SW-1:0] settle_cnt_reg, settle_cnt_next;
   logic [9:0]    h_cnt_reg, h_cnt_next;
   logic [9:0]    v_cnt_reg, v_cnt_next;

   logic       hsync_n_reg, vsync_n_reg, de_reg, line_start_reg, frame_start_reg, running_reg;
   logic [9:0] x_reg, y_reg;
   logic       hsync_n_next, vsync_n_next, de_next, line_start_next, frame_start_next, running_next;
   logic [9:0] x_next, y_next;
   logic       active;

   // locked comes from the PLL, asynchronous to refclk
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         lock_meta_reg <= 1'b0;
         locked_s_reg  <= 1'b0;
      end else begin
         lock_meta_reg <= locked;
         locked_s_reg  <= lock_meta_reg;
      end
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_reg      <= WAIT_LOCK;
         settle_cnt_reg <= '0;
         h_cnt_reg      <= '0;
         v_cnt_reg      <= '0;
      end else begin
         state_reg      <= state_next;
         settle_cnt_reg <= settle_cnt_next;
         h_cnt_reg      <= h_cnt_next;
         v_cnt_reg      <= v_cnt_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      settle_cnt_next = settle_cnt_reg;
      h_cnt_next      = h_cnt_reg;
      v_cnt_next      = v_cnt_reg;
      if (!locked_s_reg) begin
         state_next      = WAIT_LOCK;
         settle_cnt_next = '0;
         h_cnt_next      = '0;
         v_cnt_next      = '0;
      end else begin
         case (state_reg)
            WAIT_LOCK: begin
               state_next      = SETTLE;
               settle_cnt_next = '0;
            end
            SETTLE: begin
               if (settle_cnt_reg == SETTLE_LAST) begin
                  state_next = RUN;
                  h_cnt_next = '0;
                  v_cnt_next = '0;
               end else begin
                  settle_cnt_next = settle_cnt_reg + 1'b1;
               end
            end
            RUN: begin
               if (h_cnt_reg == H_LAST) begin
                  h_cnt_next = '0;
                  v_cnt_next = (v_cnt_reg == V_LAST) ? 10'd0 : v_cnt_reg + 10'd1;
               end else begin
                  h_cnt_next = h_cnt_reg + 10'd1;
               end
            end
            default: state_next = WAIT_LOCK;
         endcase
      end
   end

   // A lock loss clears outputs on the same edge that returns the FSM to WAIT_LOCK
   always_comb begin
      active           = (state_reg == RUN) && locked_s_reg;
      running_next     = (state_next == RUN);
      x_next           = active ? h_cnt_reg : 10'd0;
      y_next           = active ? v_cnt_reg : 10'd0;
      de_next          = active && (h_cnt_reg < H_ACT_W) && (v_cnt_reg < V_ACT_W);
      hsync_n_next     = !(active && (h_cnt_reg >= H_SYNC_BEG) && (h_cnt_reg < H_SYNC_END));
      vsync_n_next     = !(active && (v_cnt_reg >= V_SYNC_BEG) && (v_cnt_reg < V_SYNC_END));
      line_start_next  = active && (h_cnt_reg == 10'd0) && (v_cnt_reg < V_ACT_W);
      frame_start_next = active && (h_cnt_reg == 10'd0) && (v_cnt_reg == 10'd0);
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         hsync_n_reg     <= 1'b1;
         vsync_n_reg     <= 1'b1;
         de_reg          <= 1'b0;
         x_reg           <= '0;
         y_reg           <= '0;
         line_start_reg  <= 1'b0;
         frame_start_reg <= 1'b0;
         running_reg     <= 1'b0;
      end else begin
         hsync_n_reg     <= hsync_n_next;
         vsync_n_reg     <= vsync_n_next;
         de_reg          <= de_next;
         x_reg           <= x_next;
         y_reg           <= y_next;
         line_start_reg  <= line_start_next;
         frame_start_reg <= frame_start_next;
         running_reg     <= running_next;
      end
   end

   assign vid.hsync_n     = hsync_n_reg;
   assign vid.vsync_n     = vsync_n_reg;
   assign vid.de          = de_reg;
   assign vid.x           = x_reg;
   assign vid.y           = y_reg;
   assign vid.line_start  = line_start_reg;
   assign vid.frame_start = frame_start_reg;
   assign vid.running     = running_reg;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a shrunken raster so several frames fit in a short run.
module tb_vga_timing_gen;
   localparam int H_ACT = 16, H_FP = 4, H_SYNC = 6, H_BP = 6;
   localparam int V_ACT = 12, V_FP = 2, V_SYNC = 2, V_BP = 3;
   localparam int LS = 8;
   localparam int HT = H_ACT + H_FP + H_SYNC + H_BP;
   localparam int VT = V_ACT + V_FP + V_SYNC + V_BP;
   localparam int FR = HT * VT;

   logic refclk = 1'b0;
   logic rst    = 1'b1;
   logic locked = 1'b0;

   vga_timing_gen_if vid ();

   vga_timing_gen #(
      .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .LOCK_SETTLE(LS)
   ) dut (
      .refclk(refclk),
      .rst(rst),
      .locked(locked),
      .vid(vid)
   );

   always #5 refclk = ~refclk;

   typedef struct {
      bit         lk;
      bit         run;
      bit         de;
      bit         fs;
      logic [9:0] x;
      logic [9:0] y;
   } vec_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   bit          meta_m = 0, ls_m = 0;
   int          streak = 0;
   logic [25:0] exp_v;

   // Expected outputs as a function of how many edges locked_s has been continuously high
   function automatic logic [25:0] model_out(input int s);
      logic [25:0] v;
      int k, xx, yy;
      v = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0};
      if (s >= LS + 1) v[25] = 1'b1;
      if (s >= LS + 2) begin
         k  = s - (LS + 2);
         xx = k % HT;
         yy = (k / HT) % VT;
         v[24]    = !(xx >= H_ACT + H_FP && xx < H_ACT + H_FP + H_SYNC);
         v[23]    = !(yy >= V_ACT + V_FP && yy < V_ACT + V_FP + V_SYNC);
         v[22]    = (xx < H_ACT) && (yy < V_ACT);
         v[21]    = (xx == 0) && (yy < V_ACT);
         v[20]    = (xx == 0) && (yy == 0);
         v[19:10] = 10'(xx);
         v[9:0]   = 10'(yy);
      end
      return v;
   endfunction

   function automatic logic [25:0] dut_out();
      return {vid.running, vid.hsync_n, vid.vsync_n, vid.de, vid.line_start,
              vid.frame_start, vid.x, vid.y};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step(input bit lk);
      locked = lk;
      @(posedge refclk);
      if (rst) begin
         meta_m = 0; ls_m = 0; streak = 0;
      end else begin
         streak = ls_m ? streak + 1 : 0;
         ls_m   = meta_m;
         meta_m = lk;
      end
      exp_v = model_out(streak);
      #1;
      check("raster", 32'(dut_out()), 32'(exp_v));
   endtask

   vec_t tbl[14];

   initial begin
      int fs_q[$];
      int de_cnt, vs_cnt, hs_cnt, ls_cnt, wraps, run_len, max_run, cnt;
      bit saw_run, saw_de, prev_end;

      for (int i = 0; i < 10; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0};
      tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0};
      tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0};
      tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 10'd1, 10'd0};
      tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 10'd2, 10'd0};

      // Reset held with lock low: everything idle throughout
      for (int i = 0; i < 100; i++) step(1'b0);
      check("reset_idle", 32'(dut_out()), 32'(model_out(0)));
      $display("reset phase done: %0d compared", n_cmp);

      rst = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b0);

      // Start-up latency, E1 is the first entry
      for (int i = 0; i < 14; i++) begin
         step(tbl[i].lk);
         check($sformatf("startup[%0d].running", i), 32'(vid.running), 32'(tbl[i].run));
         check($sformatf("startup[%0d].de", i), 32'(vid.de), 32'(tbl[i].de));
         check($sformatf("startup[%0d].frame_start", i), 32'(vid.frame_start), 32'(tbl[i].fs));
         check($sformatf("startup[%0d].x", i), 32'(vid.x), 32'(tbl[i].x));
         check($sformatf("startup[%0d].y", i), 32'(vid.y), 32'(tbl[i].y));
         $display("startup E%0d: running=%0b de=%0b fs=%0b x=%0d y=%0d",
                  i + 1, vid.running, vid.de, vid.frame_start, vid.x, vid.y);
      end

      // Three full frames of free-running raster
      de_cnt = 0; vs_cnt = 0; hs_cnt = 0; ls_cnt = 0; wraps = 0; run_len = 0; max_run = 0;
      prev_end = 0;
      for (int c = 0; c < 3 * FR; c++) begin
         step(1'b1);
         if (vid.frame_start) fs_q.push_back(c);
         if (vid.de) begin de_cnt++; run_len++; if (run_len > max_run) max_run = run_len; end
         else run_len = 0;
         if (!vid.vsync_n) vs_cnt++;
         if (!vid.hsync_n) hs_cnt++;
         if (vid.line_start) ls_cnt++;
         if (prev_end && vid.x == 10'd0 && vid.y == 10'd0) wraps++;
         prev_end = (vid.x == 10'(HT - 1)) && (vid.y == 10'(VT - 1));
      end
      check("frame_start_count", 32'(fs_q.size()), 32'd3);
      if (fs_q.size() == 3) begin
         check("frame_spacing0", 32'(fs_q[1] - fs_q[0]), 32'(FR));
         check("frame_spacing1", 32'(fs_q[2] - fs_q[1]), 32'(FR));
      end
      check("de_cycles", 32'(de_cnt), 32'(3 * H_ACT * V_ACT));
      check("de_run_len", 32'(max_run), 32'(H_ACT));
      check("vsync_low_cycles", 32'(vs_cnt), 32'(3 * V_SYNC * HT));
      check("hsync_low_cycles", 32'(hs_cnt), 32'(3 * VT * H_SYNC));
      check("line_start_count", 32'(ls_cnt), 32'(3 * V_ACT));
      check("y_wrap_count", 32'(wraps), 32'd3);
      $display("frames phase done: de=%0d vs=%0d hs=%0d ls=%0d", de_cnt, vs_cnt, hs_cnt, ls_cnt);

      // Lock loss mid-frame, then restart latency
      cnt = 0;
      while (!(exp_v[19:10] == 10'd10 && exp_v[9:0] == 10'd7) && cnt < 2 * FR) begin
         step(1'b1);
         cnt++;
      end
      check("reach_mid_frame", 32'(cnt < 2 * FR), 32'd1);
      cnt = 0;
      do begin
         step(1'b0);
         cnt++;
      end while (dut_out() !== model_out(0) && cnt < 10);
      check("loss_to_idle_cycles_le3", 32'(cnt <= 3), 32'd1);
      check("loss_running", 32'(vid.running), 32'd0);
      for (int i = 0; i < 4; i++) step(1'b0);
      cnt = 0;
      do begin
         step(1'b1);
         cnt++;
      end while (!vid.frame_start && cnt < 50);
      check("relock_latency", 32'(cnt), 32'(LS + 4));
      $display("lock loss phase done: relock latency=%0d", cnt);

      // Short lock glitch never reaches RUN
      for (int i = 0; i < 6; i++) step(1'b0);
      saw_run = 0; saw_de = 0;
      for (int i = 0; i < 25; i++) begin
         step(i < 5);
         saw_run |= vid.running;
         saw_de  |= vid.de;
      end
      check("glitch_running", 32'(saw_run), 32'd0);
      check("glitch_de", 32'(saw_de), 32'd0);
      $display("glitch phase done");

      // Random lock segments against the model
      for (int seg = 0; seg < 25; seg++) begin
         int hi_len, lo_len;
         hi_len = $urandom_range(1, 700);
         lo_len = $urandom_range(1, 6);
         for (int i = 0; i < hi_len; i++) step(1'b1);
         for (int i = 0; i < lo_len; i++) step(1'b0);
         $display("random seg %0d: high=%0d low=%0d", seg, hi_len, lo_len);
      end

      // Asynchronous reset in the middle of a running raster
      for (int i = 0; i < LS + 20; i++) step(1'b1);
      check("pre_reset_running", 32'(vid.running), 32'd1);
      #2 rst = 1'b1;
      #1 check("async_reset_idle", 32'(dut_out()), 32'(model_out(0)));
      for (int i = 0; i < 3; i++) step(1'b1);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b0);
      $display("async reset phase done");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
